// File: rtl/alu_dec_pkg.sv
// alu_dec_pkg: opcode table, flag masks, decode record and FSM states for the ALU decoder
package alu_dec_pkg;
  localparam int N_OP = 25;
  typedef enum logic [4:0] {
    OP_ADD, OP_ADC, OP_ADIW, OP_SUB, OP_SUBI, OP_SBC, OP_SBCI, OP_SBIW, OP_AND, OP_ANDI,
    OP_OR, OP_ORI, OP_EOR, OP_COM, OP_NEG, OP_INC, OP_DEC, OP_CP, OP_CPC, OP_CPI,
    OP_CPSE, OP_LSR, OP_ROR, OP_ASR, OP_SWAP
  } op_e;
  typedef enum logic {S_IDLE, S_W2} state_e;
  localparam int FL_C = 0;
  localparam int FL_Z = 1;
  localparam int FL_N = 2;
  localparam int FL_V = 3;
  localparam int FL_S = 4;
  localparam int FL_H = 5;
  localparam logic [7:0] FL_ARITH = 8'h3F;
  localparam logic [7:0] FL_LOGIC = 8'h1E;
  localparam logic [7:0] FL_SHIFT = 8'h1F;
  localparam logic [7:0] FL_NONE = 8'h00;
  localparam logic [15:0] M_R2 = 16'hFC00;
  localparam logic [15:0] M_IMM = 16'hF000;
  localparam logic [15:0] M_W = 16'hFF00;
  localparam logic [15:0] M_R1 = 16'hFE0F;
  // entries are indexed by op_e
  localparam logic [15:0] OP_MASK [N_OP] = '{
    M_R2, M_R2, M_W, M_R2, M_IMM, M_R2, M_IMM, M_W, M_R2, M_IMM,
    M_R2, M_IMM, M_R2, M_R1, M_R1, M_R1, M_R1, M_R2, M_R2, M_IMM,
    M_R2, M_R1, M_R1, M_R1, M_R1};
  localparam logic [15:0] OP_VAL [N_OP] = '{
    16'h0C00, 16'h1C00, 16'h9600, 16'h1800, 16'h5000, 16'h0800, 16'h4000, 16'h9700, 16'h2000, 16'h7000,
    16'h2800, 16'h6000, 16'h2400, 16'h9400, 16'h9401, 16'h9403, 16'h940A, 16'h1400, 16'h0400, 16'h3000,
    16'h1000, 16'h9406, 16'h9407, 16'h9405, 16'h9402};
  localparam logic [7:0] OP_FL [N_OP] = '{
    FL_ARITH, FL_ARITH, FL_SHIFT, FL_ARITH, FL_ARITH, FL_ARITH, FL_ARITH, FL_SHIFT, FL_LOGIC, FL_LOGIC,
    FL_LOGIC, FL_LOGIC, FL_LOGIC, FL_SHIFT, FL_ARITH, FL_LOGIC, FL_LOGIC, FL_ARITH, FL_ARITH, FL_ARITH,
    FL_NONE, FL_SHIFT, FL_SHIFT, FL_SHIFT, FL_NONE};
  typedef struct packed {
    logic hit;
    op_e op;
    logic [4:0] rd;
    logic [4:0] rr;
    logic [7:0] imm;
    logic imm_sel;
    logic wr;
    logic [7:0] fl;
  } dec_t;
endpackage

// File: rtl/alu_op_lut.sv
// alu_op_lut: combinational opcode to operand/strobe/flag-mask lookup
module alu_op_lut
  import alu_dec_pkg::*;
(
  input  logic [15:0] inst,
  output dec_t        dec
);
  logic [15:0] msk;
  always_comb begin
    dec = '0;
    msk = '0;
    for (int i = 0; i < N_OP; i++)
      if ((inst & OP_MASK[i]) == OP_VAL[i]) begin
        dec.hit = 1'b1;
        dec.op = op_e'(5'(i));
        msk = OP_MASK[i];
      end
    dec.rd = msk == M_IMM ? {1'b1, inst[7:4]} : msk == M_W ? {2'b11, inst[5:4], 1'b0} : inst[8:4];
    dec.rr = msk == M_R2 ? {inst[9], inst[3:0]} : dec.rd;
    dec.imm = msk == M_IMM ? {inst[11:8], inst[3:0]} : msk == M_W ? {2'b00, inst[7:6], inst[3:0]} : 8'h00;
    dec.imm_sel = msk == M_IMM || msk == M_W;
    dec.wr = dec.hit && !(dec.op inside {OP_CP, OP_CPC, OP_CPI, OP_CPSE});
    dec.fl = dec.hit ? OP_FL[dec.op] : FL_NONE;
  end
endmodule

// File: rtl/alu_inst_dec.sv
// alu_inst_dec: AVR ALU-class decoder with ADIW/SBIW two-cycle sequencing and CPSE skip
module alu_inst_dec
  import alu_dec_pkg::*;
#(
  parameter bit SKIP_EN = 1'b1,
  parameter bit ILL_NOP = 1'b1
) (
  input  logic        cp2,
  input  logic        cp2en,
  input  logic        ireset,
  input  logic [15:0] inst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic        cpse_eq,
  output logic        idc_add, idc_adc, idc_adiw, idc_sub, idc_subi, idc_sbc, idc_sbci,
  output logic        idc_sbiw, idc_and, idc_andi, idc_or, idc_ori, idc_eor, idc_com,
  output logic        idc_neg, idc_inc, idc_dec, idc_cp, idc_cpc, idc_cpi, idc_cpse,
  output logic        idc_lsr, idc_ror, idc_asr, idc_swap,
  output logic        adiw_st,
  output logic        sbiw_st,
  output logic [4:0]  reg_rd_adr,
  output logic [4:0]  reg_rr_adr,
  output logic [7:0]  imm,
  output logic        imm_sel,
  output logic        reg_rd_wr,
  output logic [7:0]  sreg_fl_wr_en,
  output logic        skipped,
  output logic        ill_op
);
  localparam logic [N_OP-1:0] ONE = N_OP'(1);
  dec_t dec;
  state_e state;
  logic [N_OP-1:0] strb;
  logic skip_pend, w2_sq, w2_sbiw, accept, squash;
  logic [4:0] w2_rd;
  alu_op_lut u_lut (.inst(inst), .dec(dec));
  assign {idc_swap, idc_asr, idc_ror, idc_lsr, idc_cpse, idc_cpi, idc_cpc, idc_cp, idc_dec,
          idc_inc, idc_neg, idc_com, idc_eor, idc_ori, idc_or, idc_andi, idc_and, idc_sbiw,
          idc_sbci, idc_sbc, idc_subi, idc_sub, idc_adiw, idc_adc, idc_add} = strb;
  assign inst_ready = state == S_IDLE;
  assign accept = inst_valid & inst_ready & cp2en;
  // a CPSE whose result is visible now can squash the instruction accepted in the same cycle
  assign squash = skip_pend | (idc_cpse & cpse_eq & SKIP_EN);
  always_ff @(posedge cp2)
    if (ireset) begin
      state <= S_IDLE;
      {skip_pend, w2_sq, w2_sbiw, w2_rd} <= '0;
      {strb, adiw_st, sbiw_st, reg_rd_adr, reg_rr_adr, imm, imm_sel} <= '0;
      {reg_rd_wr, sreg_fl_wr_en, skipped, ill_op} <= '0;
    end else if (cp2en) begin
      state <= S_IDLE;
      skip_pend <= squash;
      {strb, adiw_st, sbiw_st, reg_rd_adr, reg_rr_adr, imm, imm_sel} <= '0;
      {reg_rd_wr, sreg_fl_wr_en, skipped, ill_op} <= '0;
      if (state == S_W2) begin
        if (!w2_sq) begin
          strb <= ONE << (w2_sbiw ? OP_SBIW : OP_ADIW);
          adiw_st <= !w2_sbiw;
          sbiw_st <= w2_sbiw;
          reg_rd_adr <= w2_rd + 5'd1;
          reg_rr_adr <= w2_rd + 5'd1;
          imm_sel <= 1'b1;
          reg_rd_wr <= 1'b1;
          sreg_fl_wr_en <= FL_SHIFT;
        end
      end else if (accept) begin
        skip_pend <= 1'b0;
        if (dec.hit && dec.op inside {OP_ADIW, OP_SBIW}) state <= S_W2;
        w2_sq <= squash;
        w2_sbiw <= dec.op == OP_SBIW;
        w2_rd <= dec.rd;
        if (squash) skipped <= 1'b1;
        else if (!dec.hit) ill_op <= ILL_NOP;
        else begin
          strb <= ONE << dec.op;
          reg_rd_adr <= dec.rd;
          reg_rr_adr <= dec.rr;
          imm <= dec.imm;
          imm_sel <= dec.imm_sel;
          reg_rd_wr <= dec.wr;
          sreg_fl_wr_en <= dec.fl;
        end
      end
    end
endmodule
